bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter AW, default 24: address width for both requesters and the memory port.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter RD_LAT, default 1: block-RAM read latency in cycles, legal range 1..4.
REQ-004 Parameter STARVE_MAX, default 8: maximum consecutive cycles an audio request may wait while VGA wins; legal range 1..15.
REQ-005 CLK_I  in  1  sole clock; every register is clocked on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 vga_blank  in  1  1 = display outside the active area; audio gets priority.
REQ-008 vga_req  in  1  VGA glyph-fetch read request, held until accepted.
REQ-009 vga_addr  in  AW  VGA read address.
REQ-010 vga_ack  out  1  VGA request accepted this cycle.
REQ-011 vga_rvalid  out  1  vga_rdata is valid this cycle.
REQ-012 vga_rdata  out  DW  read data returned to VGA.
REQ-013 aud_req  in  1  audio request, held until accepted.
REQ-014 aud_we  in  1  1 = write, 0 = read.
REQ-015 aud_addr  in  AW  audio address.
REQ-016 aud_wdata  in  DW  audio write data.
REQ-017 aud_ack  out  1  audio request accepted this cycle.
REQ-018 aud_rvalid  out  1  aud_rdata is valid this cycle.
REQ-019 aud_rdata  out  DW  read data returned to audio.
REQ-020 mem_en, mem_we  out  1 each  block-RAM enable and write strobe.
REQ-021 mem_addr  out  AW  block-RAM address.
REQ-022 mem_wdata  out  DW  block-RAM write data.
REQ-023 mem_rdata  in  DW  block-RAM read data, valid RD_LAT cycles after a read issues.

Function
REQ-024 A transfer occurs on a rising edge where req && ack; acks are combinational from the req inputs and registered state; at most one ack is high per cycle.
REQ-025 Arbitration state machine:
- PRI_VGA: selected when vga_blank=0 and starve_cnt<STARVE_MAX; VGA wins any conflict.
- PRI_AUD: selected when vga_blank=1; audio wins any conflict.
- FORCE_AUD: selected when vga_blank=0 and starve_cnt==STARVE_MAX; audio wins exactly one grant, then the state returns to PRI_VGA.
REQ-026 A single request with no competitor is always acked in the same cycle, in every state.
REQ-027 Starvation counter starve_cnt (4 bits):
- increments when aud_req=1, aud_ack=0 and vga_ack=1;
- clears on any aud_ack or when aud_req=0;
- saturates at STARVE_MAX.
REQ-028 Accepted transfer at edge N:
- mem_en=1 and mem_we/mem_addr/mem_wdata are driven from registers during cycle N+1;
- mem_en=0 and mem_we=0 in every cycle with no accepted transfer;
- mem_addr and mem_wdata hold their last values when idle.
REQ-029 For a VGA transfer, mem_we=0 and mem_wdata holds its last value.
REQ-030 Each accepted read pushes an owner tag (VGA or AUD) into an RD_LAT+1 deep shift pipeline.
REQ-031 Read return:
- the tag emerges in cycle N+1+RD_LAT;
- the matching rvalid is asserted for exactly one cycle in that cycle;
- the matching rdata is registered from mem_rdata;
- audio writes push a null tag and never assert rvalid.
REQ-032 Read data is returned to each requester in issue order; no return is dropped or duplicated.
REQ-033 Throughput is one transfer per cycle; back-to-back grants to the same requester are legal.
REQ-034 A vga_blank transition takes effect on the arbitration decision in the same cycle; in-flight reads are unaffected.

Reset
REQ-035 While reset=0, the following hold:
- outputs: vga_ack, aud_ack, vga_rvalid, aud_rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata, vga_rdata, aud_rdata = 0;
- state: arbiter state = PRI_VGA, starve_cnt = 0, tag pipeline cleared.
REQ-036 Reads in flight when reset asserts are discarded; no rvalid for them appears after reset releases.
REQ-037 The first grant can occur in the first cycle after reset deasserts.

Verification
REQ-038 vga_blank=0, vga_req and aud_req held high with aud_we=0 -> VGA acked 8 consecutive cycles, then audio acked once (FORCE_AUD), then VGA resumes.
REQ-039 vga_blank=1, both requesting -> aud_ack every cycle, vga_ack stays 0, starve_cnt stays 0.
REQ-040 Single VGA read of addr 0x000010, BRAM returns 0xDEADBEEF, RD_LAT=1:
- mem_en=1 in cycle N+1;
- vga_rvalid=1 with vga_rdata=0xDEADBEEF in cycle N+2;
- aud_rvalid stays 0.
REQ-041 Alternating VGA read / audio write / audio read, RD_LAT=2:
- rvalid pulses arrive in issue order;
- the write produces no rvalid;
- mem_we=1 only in the cycle after the write is acked.
REQ-042 Assert reset while 2 reads are in flight:
- all outputs go to 0 immediately;
- no rvalid appears after reset releases;
- a new request is acked in the first cycle after release.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-requester block-RAM arbiter: VGA glyph fetches vs. audio read/write, with
// blank-interval audio priority, a starvation guard and in-order read return.
module bram_arbiter #(
    parameter int unsigned AW         = 24,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          CLK_I,
    input  logic          reset,
    input  logic          vga_blank,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_ack,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,
    input  logic          aud_req,
    input  logic          aud_we,
    input  logic [AW-1:0] aud_addr,
    input  logic [DW-1:0] aud_wdata,
    output logic          aud_ack,
    output logic          aud_rvalid,
    output logic [DW-1:0] aud_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        PRI_VGA   = 2'd0,
        PRI_AUD   = 2'd1,
        FORCE_AUD = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_AUD  = 2'd2
    } tag_e;

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          aud_pri_c;
    tag_e          push_c;
    tag_e          tag_q [RD_LAT+1];

    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] vga_rdata_q, aud_rdata_q;

    // Arbitration state register
    always_ff @(posedge CLK_I or negedge reset) begin
        if (!reset) begin
            state_q  <= PRI_VGA;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Grant decision and next state; vga_blank acts on the current decision directly
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        aud_pri_c = 1'b0;
        vga_ack   = 1'b0;
        aud_ack   = 1'b0;
        push_c    = TAG_NONE;

        if (vga_blank || (state_q == FORCE_AUD)) begin
            aud_pri_c = 1'b1;
        end

        if (reset) begin
            if (aud_req && (aud_pri_c || !vga_req)) begin
                aud_ack = 1'b1;
            end else if (vga_req) begin
                vga_ack = 1'b1;
            end
        end

        if (!aud_req || aud_ack) begin
            starve_d = '0;
        end else if (vga_ack && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end

        if (starve_d == STARVE_LIM) begin
            state_d = FORCE_AUD;
        end else if (vga_blank) begin
            state_d = PRI_AUD;
        end else begin
            state_d = PRI_VGA;
        end

        if (vga_ack) begin
            push_c = TAG_VGA;
        end else if (aud_ack && !aud_we) begin
            push_c = TAG_AUD;
        end
    end

    // Memory command registers; address/data hold when idle
    always_ff @(posedge CLK_I or negedge reset) begin
        if (!reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= vga_ack | aud_ack;
            mem_we_q <= aud_ack & aud_we;
            if (aud_ack) begin
                mem_addr_q  <= aud_addr;
                mem_wdata_q <= aud_wdata;
            end else if (vga_ack) begin
                mem_addr_q <= vga_addr;
            end
        end
    end

    // Owner-tag pipeline; stage RD_LAT is the rvalid cycle, data sampled one edge earlier
    always_ff @(posedge CLK_I or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
            vga_rdata_q <= '0;
            aud_rdata_q <= '0;
        end else begin
            tag_q[0] <= push_c;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (tag_q[RD_LAT-1] == TAG_VGA) begin
                vga_rdata_q <= mem_rdata;
            end
            if (tag_q[RD_LAT-1] == TAG_AUD) begin
                aud_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign vga_rvalid = (tag_q[RD_LAT] == TAG_VGA);
    assign aud_rvalid = (tag_q[RD_LAT] == TAG_AUD);
    assign vga_rdata  = vga_rdata_q;
    assign aud_rdata  = aud_rdata_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus randomized traffic, checked
// against a cycle-level scoreboard of grants, memory commands and read returns.
module tb_bram_arbiter;

    localparam int unsigned AW         = 24;
    localparam int unsigned DW         = 32;
    localparam int unsigned RD_LAT     = 2;
    localparam int          STARVE_MAX = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vga_blank = 1'b0, vga_req = 1'b0, aud_req = 1'b0, aud_we = 1'b0;
    logic [AW-1:0] vga_addr = '0, aud_addr = '0;
    logic [DW-1:0] aud_wdata = '0, mem_rdata = '0;
    logic          vga_ack, vga_rvalid, aud_ack, aud_rvalid, mem_en, mem_we;
    logic [DW-1:0] vga_rdata, aud_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    bram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK_I(clk), .reset(rst_n), .vga_blank(vga_blank),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .aud_req(aud_req), .aud_we(aud_we), .aud_addr(aud_addr), .aud_wdata(aud_wdata),
        .aud_ack(aud_ack), .aud_rvalid(aud_rvalid), .aud_rdata(aud_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    // Scoreboard: starvation count, held memory registers, returns keyed by edge number
    int            st;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_vdata, e_adata;
    int            rd_owner [16];
    logic [DW-1:0] rd_data  [16];
    logic          obs_v, obs_a;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        st = 0;
        e_addr = '0; e_wdata = '0; e_vdata = '0; e_adata = '0;
        for (int i = 0; i < 16; i++) begin
            rd_owner[i] = 0;
            rd_data[i]  = '0;
        end
    endtask

    task automatic step(input logic blank, input logic vr, input logic [AW-1:0] va,
                        input logic ar, input logic aw, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad);
        int   u, e, slot;
        logic ev, ea, aud_wins;
        @(negedge clk);
        vga_blank = blank; vga_req = vr; vga_addr = va;
        aud_req = ar; aud_we = aw; aud_addr = aa; aud_wdata = ad;
        u = cyc + 1;
        mem_rdata = (rd_owner[u % 16] != 0) ? rd_data[u % 16] : DW'($urandom);
        #1;
        aud_wins = blank || (st == STARVE_MAX);
        ea = ar && (aud_wins || !vr);
        ev = vr && !ea;
        obs_v = vga_ack;
        obs_a = aud_ack;
        check("vga_ack", 64'(vga_ack), 64'(ev));
        check("aud_ack", 64'(aud_ack), 64'(ea));
        @(posedge clk);
        #1;
        e = cyc;
        if (!ar || ea) st = 0;
        else if (ev && st < STARVE_MAX) st++;
        if (ea) begin
            e_addr = aa;
            e_wdata = ad;
        end else if (ev) begin
            e_addr = va;
        end
        check("mem_en", 64'(mem_en), 64'(ev | ea));
        check("mem_we", 64'(mem_we), 64'(ea & aw));
        check("mem_addr", 64'(mem_addr), 64'(e_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(mem_wdata === e_wdata ? e_wdata : e_wdata));
        slot = e % 16;
        if (rd_owner[slot] == 1) e_vdata = rd_data[slot];
        if (rd_owner[slot] == 2) e_adata = rd_data[slot];
        check("vga_rvalid", 64'(vga_rvalid), 64'(rd_owner[slot] == 1));
        check("aud_rvalid", 64'(aud_rvalid), 64'(rd_owner[slot] == 2));
        check("vga_rdata", 64'(vga_rdata), 64'(e_vdata));
        check("aud_rdata", 64'(aud_rdata), 64'(e_adata));
        rd_owner[slot] = 0;
        if (ev || (ea && !aw)) begin
            slot = (e + int'(RD_LAT)) % 16;
            rd_owner[slot] = ev ? 1 : 2;
            rd_data[slot]  = DW'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Assert reset mid-cycle, check the forced-zero outputs, release just after an edge
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vga_req = 1'b1; aud_req = 1'b1;
        #1;
        check("rst_vga_ack", 64'(vga_ack), 64'(0));
        check("rst_aud_ack", 64'(aud_ack), 64'(0));
        check("rst_mem_en", 64'(mem_en), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_vga_rvalid", 64'(vga_rvalid), 64'(0));
        check("rst_aud_rvalid", 64'(aud_rvalid), 64'(0));
        check("rst_vga_rdata", 64'(vga_rdata), 64'(0));
        check("rst_aud_rdata", 64'(aud_rdata), 64'(0));
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_mem_en", 64'(mem_en), 64'(0));
        check("rst_hold_rvalid", 64'({vga_rvalid, aud_rvalid}), 64'(0));
        vga_req = 1'b0; aud_req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    logic          vp, ap, apw, blk;
    logic [AW-1:0] va, aa;
    logic [DW-1:0] ad;

    initial begin
        model_clear();
        do_reset();

        // Single VGA read with known BRAM data
        step(1'b0, 1'b1, 24'h000010, 1'b0, 1'b0, '0, '0);
        rd_data[(cyc + int'(RD_LAT)) % 16] = 32'hDEADBEEF;
        idle(int'(RD_LAT) + 1);
        check("deadbeef", 64'(vga_rdata), 64'(32'hDEADBEEF));

        // Starvation guard: 8 VGA grants, one forced audio grant, VGA resumes
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, 24'h000100, '0);
            check("force_seq_aud", 64'(obs_a), 64'(i == 8));
            check("force_seq_vga", 64'(obs_v), 64'(i != 8));
        end

        // Blanking: audio wins every conflict
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, AW'(i), 1'b1, 1'b0, AW'(i + 16), '0);
            check("blank_aud", 64'(obs_a), 64'(1));
            check("blank_vga", 64'(obs_v), 64'(0));
        end
        idle(4);

        // VGA read, audio write, audio read
        step(1'b0, 1'b1, 24'h000020, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 24'h000030, 32'h12345678);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 24'h000030, '0);
        idle(4);

        // Reset with two reads in flight, then an immediate grant
        step(1'b0, 1'b1, 24'h000050, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 24'h000060, '0);
        do_reset();
        step(1'b0, 1'b1, 24'h000040, 1'b0, 1'b0, '0, '0);
        check("post_reset_ack", 64'(obs_v), 64'(1));
        idle(4);

        // Randomized traffic; requests are held until granted
        vp = 1'b0; ap = 1'b0; apw = 1'b0; blk = 1'b0; va = '0; aa = '0; ad = '0;
        for (int i = 0; i < 400; i++) begin
            if (!vp && $urandom_range(0, 3) != 0) begin
                vp = 1'b1;
                va = AW'($urandom);
            end
            if (!ap && $urandom_range(0, 2) == 0) begin
                ap  = 1'b1;
                apw = 1'($urandom_range(0, 1));
                aa  = AW'($urandom);
                ad  = DW'($urandom);
            end
            if ($urandom_range(0, 7) == 0) blk = ~blk;
            step(blk, vp, va, ap, apw, aa, ad);
            if (obs_v) vp = 1'b0;
            if (obs_a) ap = 1'b0;
        end
        idle(int'(RD_LAT) + 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
